// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared state encoding and index helper for bus_grant_arb
// Contents:
//   arb_state_e : arbiter FSM states. GNT_LOCKED exists only when BUS_ARB_LOCK_EN is defined.
//   next_idx    : (idx + 1) mod n without a divider.
package bus_arb_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GNT        = 3'd1,
`ifdef BUS_ARB_LOCK_EN
        GNT_LOCKED = 3'd2,
`endif
        OWNED      = 3'd3,
        TOUT       = 3'd4
    } arb_state_e;

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick of the first request at or after a pointer
// Ports:
//   req_i   [NUM_REQ] : request vector
//   ptr_i   [IDW]     : search start index (always < NUM_REQ)
//   pick_o  [NUM_REQ] : one-hot selected request, zero when no request
//   idx_o   [IDW]     : index of the selected request
//   valid_o           : some request is pending
module rr_picker #(
    parameter int NUM_REQ = 4,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic [IDW-1:0]     idx_o,
    output logic               valid_o
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] slot;

    // Walk the channels starting at the pointer and wrapping; the first hit wins.
    always_comb begin
        pick_o  = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        sum     = '0;
        slot    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum  = {1'b0, ptr_i} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NUM_REQ)) begin
                sum = sum - (IDW+1)'(NUM_REQ);
            end
            slot = sum[IDW-1:0];
            if (!valid_o && req_i[slot]) begin
                valid_o      = 1'b1;
                pick_o[slot] = 1'b1;
                idx_o        = slot;
            end
        end
    end

endmodule

// File: rtl/bus_grant_arb.sv
// rtl/bus_grant_arb.sv - round-robin bus arbiter with grant and ownership timeouts
// Optional feature macro: BUS_ARB_LOCK_EN (owner keeps the bus across frames while lock is high).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   req      [NUM_REQ]  : per-channel level request
//   frame               : transaction active from the granted master
//   lock                : hold bus across frames (unused unless BUS_ARB_LOCK_EN)
//   grant    [NUM_REQ]  : registered one-hot grant
//   owner_id [IDW]      : granted channel index, valid while |grant
//   aquired             : granted master is in its frame
//   time_out            : one-cycle abort pulse
module bus_grant_arb
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int GRANT_TIMEOUT = 64,
    parameter int MAX_OWN       = 256,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               frame,
    input  logic               lock,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     owner_id,
    output logic               aquired,
    output logic               time_out
);

    localparam int WAIT_W = $clog2(GRANT_TIMEOUT);
    localparam int OWN_W  = $clog2(MAX_OWN);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(GRANT_TIMEOUT - 1);
    localparam logic [OWN_W-1:0]  OWN_LAST  = OWN_W'(MAX_OWN - 1);

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IDW-1:0]     owner_q;
    logic [IDW-1:0]     ptr_q;
    logic               aquired_q;
    logic               time_out_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [OWN_W-1:0]   own_q;

    logic [NUM_REQ-1:0] pick_oh;
    logic [IDW-1:0]     pick_idx;
    logic               pick_valid;
    logic [IDW-1:0]     ptr_after_owner;

`ifndef BUS_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = lock;
`endif

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .pick_o  (pick_oh),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Moving the pointer past the departing owner keeps a repeatedly aborting master from starving others.
    assign ptr_after_owner = IDW'(next_idx(int'(owner_q), NUM_REQ));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            aquired_q  <= 1'b0;
            time_out_q <= 1'b0;
            wait_q     <= '0;
            own_q      <= '0;
        end else begin
            time_out_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick_oh;
                        owner_q <= pick_idx;
                        wait_q  <= '0;
                        state_q <= GNT;
                    end
                end
`ifdef BUS_ARB_LOCK_EN
                GNT, GNT_LOCKED: begin
`else
                GNT: begin
`endif
                    // frame beats a coincident timeout; an abandoned grant is not an abort
                    if (frame) begin
                        aquired_q <= 1'b1;
                        own_q     <= '0;
                        state_q   <= OWNED;
                    end else if (!req[owner_q]) begin
                        grant_q <= '0;
                        state_q <= IDLE;
                    end else if (wait_q == WAIT_LAST) begin
                        grant_q    <= '0;
                        time_out_q <= 1'b1;
                        ptr_q      <= ptr_after_owner;
                        state_q    <= TOUT;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                OWNED: begin
                    // the ownership limit wins over a release in the same cycle
                    if (own_q == OWN_LAST) begin
                        grant_q    <= '0;
                        aquired_q  <= 1'b0;
                        time_out_q <= 1'b1;
                        ptr_q      <= ptr_after_owner;
                        state_q    <= TOUT;
                    end else if (!frame) begin
                        aquired_q <= 1'b0;
`ifdef BUS_ARB_LOCK_EN
                        if (lock) begin
                            wait_q  <= '0;
                            state_q <= GNT_LOCKED;
                        end else begin
                            grant_q <= '0;
                            ptr_q   <= ptr_after_owner;
                            state_q <= IDLE;
                        end
`else
                        grant_q <= '0;
                        ptr_q   <= ptr_after_owner;
                        state_q <= IDLE;
`endif
                    end else begin
                        own_q <= own_q + 1'b1;
                    end
                end
                TOUT: begin
                    state_q <= IDLE;
                end
                default: begin
                    grant_q   <= '0;
                    aquired_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign grant    = grant_q;
    assign owner_id = owner_q;
    assign aquired  = aquired_q;
    assign time_out = time_out_q;

endmodule

// File: tb/tb_bus_grant_arb.sv
// tb/tb_bus_grant_arb.sv - self-checking bench for bus_grant_arb
module tb_bus_grant_arb;

    localparam int N  = 4;
    localparam int GT = 64;
    localparam int MO = 256;
`ifdef BUS_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         frame;
    logic         lock;
    logic [N-1:0] grant;
    logic [1:0]   owner_id;
    logic         aquired;
    logic         time_out;

    int checks = 0;
    int errors = 0;

    bus_grant_arb #(.NUM_REQ(N), .GRANT_TIMEOUT(GT), .MAX_OWN(MO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .frame    (frame),
        .lock     (lock),
        .grant    (grant),
        .owner_id (owner_id),
        .aquired  (aquired),
        .time_out (time_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 waiting for frame, 2 owned, 3 abort cycle, 4 locked wait.
    // cnt counts clock edges spent in the current waiting/owned phase.
    int m_phase, m_owner, m_ptr, m_cnt;

    task automatic model_step();
        bit found;
        int i;
        case (m_phase)
            0: begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    i = (m_ptr + k) % N;
                    if (!found && req[i]) begin
                        found   = 1'b1;
                        m_owner = i;
                        m_phase = 1;
                        m_cnt   = 0;
                    end
                end
            end
            1, 4: begin
                m_cnt++;
                if (frame) begin
                    m_phase = 2;
                    m_cnt   = 0;
                end else if (!req[m_owner]) begin
                    m_phase = 0;
                end else if (m_cnt == GT) begin
                    m_phase = 3;
                    m_ptr   = (m_owner + 1) % N;
                end
            end
            2: begin
                m_cnt++;
                if (m_cnt == MO) begin
                    m_phase = 3;
                    m_ptr   = (m_owner + 1) % N;
                end else if (!frame) begin
                    if (LOCK_EN && lock) begin
                        m_phase = 4;
                        m_cnt   = 0;
                    end else begin
                        m_phase = 0;
                        m_ptr   = (m_owner + 1) % N;
                    end
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_owner = 0;
            m_ptr   = 0;
            m_cnt   = 0;
        end else begin
            model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [N-1:0] eg;
        if (!rst) begin
            eg = (m_phase == 1 || m_phase == 2 || m_phase == 4) ? N'(1 << m_owner) : '0;
            check("model_grant", grant, eg);
            check("model_aquired", aquired, m_phase == 2);
            check("model_time_out", time_out, m_phase == 3);
            if (eg != 0) check("model_owner_id", owner_id, m_owner);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = '0;
        frame = 1'b0;
        lock  = 1'b0;
        rst   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        logic [N-1:0] rot [5];
        int fp;
        rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100; rot[3] = 4'b1000; rot[4] = 4'b0001;

        req = '0; frame = 1'b0; lock = 1'b0; rst = 1'b1;
        #3;
        check("reset_grant", grant, 0);
        check("reset_aquired", aquired, 0);
        check("reset_time_out", time_out, 0);
        check("reset_owner", owner_id, 0);
        do_reset();

        // single master
        req = 4'b0001;
        tick();
        check("single_grant", grant, 4'b0001);
        check("single_aq_early", aquired, 0);
        tick();
        tick();
        frame = 1'b1;
        tick();
        check("single_aquired", aquired, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("single_hold", aquired, 1);
        end
        frame = 1'b0;
        req   = '0;
        tick();
        check("single_release_grant", grant, 0);
        check("single_release_aq", aquired, 0);
        check("single_no_tout", time_out, 0);

        // fairness
        do_reset();
        req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            n = 0;
            while (grant == 0 && n < 10) begin
                tick();
                n++;
            end
            check("fair_grant", grant, rot[r]);
            frame = 1'b1;
            tick();
            tick();
            frame = 1'b0;
            tick();
            check("fair_gap", grant, 0);
            check("fair_no_tout", time_out, 0);
        end
        req = '0;
        tick();

        // grant timeout
        do_reset();
        req = 4'b0010;
        tick();
        check("gto_grant", grant, 4'b0010);
        n = 0;
        while (!time_out && n < 200) begin
            tick();
            n++;
        end
        check("gto_latency", n, 64);
        check("gto_grant_clear", grant, 0);
        req = 4'b1111;
        tick();
        check("gto_pulse_once", time_out, 0);
        tick();
        check("gto_ptr2", grant, 4'b0100);
        req = '0;
        tick();

        // ownership overrun
        do_reset();
        req = 4'b0001;
        tick();
        frame = 1'b1;
        tick();
        check("own_aquired", aquired, 1);
        n = 0;
        while (!time_out && n < 400) begin
            tick();
            n++;
        end
        check("own_latency", n, 256);
        check("own_grant_clear", grant, 0);
        check("own_frame_high", frame, 1);
        req = '0;
        for (int k = 0; k < 40; k++) tick();
        frame = 1'b0;
        tick();

        // abandon, then async reset mid-ownership
        do_reset();
        req = 4'b0001;
        tick();
        check("abn_grant", grant, 4'b0001);
        req = '0;
        tick();
        check("abn_grant_clear", grant, 0);
        check("abn_no_tout", time_out, 0);
        tick();
        check("abn_no_tout2", time_out, 0);
        req = 4'b0001;
        tick();
        frame = 1'b1;
        tick();
        check("rst_pre_aq", aquired, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_grant", grant, 0);
        check("rst_async_aq", aquired, 0);
        check("rst_async_tout", time_out, 0);
        tick();
        do_reset();

`ifdef BUS_ARB_LOCK_EN
        req  = 4'b0001;
        lock = 1'b1;
        tick();
        for (int p = 0; p < 3; p++) begin
            frame = 1'b1;
            tick();
            check("lock_aq_hi", aquired, 1);
            check("lock_grant_hi", grant, 4'b0001);
            frame = 1'b0;
            tick();
            check("lock_aq_lo", aquired, 0);
            check("lock_grant_lo", grant, 4'b0001);
        end
        lock = 1'b0;
        req  = '0;
        tick();
        do_reset();
`endif

        // randomized traffic in epochs of differing frame density
        for (int e = 0; e < 8; e++) begin
            fp = (e % 4 == 0) ? 0 : (e % 4 == 1) ? 10 : (e % 4 == 2) ? 50 : 97;
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, 99) < 15) req = N'($urandom_range(0, 15));
                frame = ($urandom_range(0, 99) < fp);
                lock  = ($urandom_range(0, 99) < 30);
                tick();
            end
        end
        req = '0; frame = 1'b0; lock = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
